// File: rtl/dlx_fetch_queue.sv
// DLX instruction-fetch engine: issues ROM fetches with wait-state support and
// buffers {pc, instr} pairs in a DEPTH-entry queue ahead of decode.
module dlx_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [XLEN-1:0]          i_address,
    output logic                     i_req,
    input  logic                     i_data_valid,
    input  logic [XLEN-1:0]          i_data_read,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [XLEN-1:0]          dec_instr,
    output logic [XLEN-1:0]          dec_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic            push;
    logic            pop;

    // Handshake qualifiers: redirect masks both request and decode-valid combinationally.
    assign i_req     = (state_q == ST_RUN) && !redirect_valid;
    assign dec_valid = (count_q != '0) && !redirect_valid;
    assign push      = i_req && i_data_valid;
    assign pop       = dec_valid && dec_ready;

    assign i_address = fetch_pc_q;
    assign count     = count_q;
    assign dec_instr = mem_q[rd_ptr_q].instr;
    assign dec_pc    = mem_q[rd_ptr_q].pc;

    // Next-state: queue bookkeeping, fetch PC and FSM.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;

        if (redirect_valid) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_pc;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: fetch_pc_q, instr: i_data_read};
                wr_ptr_d        = wr_ptr_q + PW'(1);
                fetch_pc_d      = fetch_pc_q + XLEN'(PC_STEP);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // FULL is decided on the post-edge count so a full queue never sees i_req.
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (count_d == CW'(DEPTH)) state_d = ST_FULL;
            ST_FULL: if (count_d < CW'(DEPTH))  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dlx_fetch_queue.sv
// Scoreboard bench for dlx_fetch_queue: an abstract queue model predicts the
// fetch address, occupancy and every entry that decode should receive.
module tb_dlx_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] RESET_PC = 32'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic                  clk;
    logic                  reset_n;
    logic [31:0]           i_address;
    logic                  i_req;
    logic                  i_data_valid;
    logic [31:0]           i_data_read;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  dec_valid;
    logic                  dec_ready;
    logic [31:0]           dec_instr;
    logic [31:0]           dec_pc;
    logic [$clog2(DEPTH):0] count;

    dlx_fetch_queue #(
        .XLEN(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_address(i_address), .i_req(i_req),
        .i_data_valid(i_data_valid), .i_data_read(i_data_read),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t        sb[$];
    ent_t        mon_e;
    logic [31:0] model_pc;
    bit          boot;
    bit          exp_ireq;
    bit          exp_dvalid;
    logic [31:0] exp_addr;
    int          exp_count;
    int          checks;
    int          failures;
    event        chk_ev;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset();
        chk("rst_i_req", 32'(i_req), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_i_address", i_address, RESET_PC);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
    endtask

    task automatic model_reset();
        sb.delete();
        model_pc = RESET_PC;
        boot     = 1'b1;
    endtask

    // One clock of stimulus; the model advances after the monitor has sampled.
    task automatic cycle(input bit v, input bit r, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        i_data_valid   = v;
        dec_ready      = r;
        redirect_valid = rd;
        redirect_pc    = rpc;
        i_data_read    = rom(i_address);
        exp_ireq   = !boot && (sb.size() < int'(DEPTH)) && !rd;
        exp_dvalid = (sb.size() != 0) && !rd;
        exp_addr   = model_pc;
        exp_count  = sb.size();
        -> chk_ev;
        #2;
        if (rd) begin
            sb.delete();
            model_pc = rpc;
        end else if (exp_ireq && v) begin
            sb.push_back('{pc: model_pc, instr: rom(model_pc)});
            model_pc = model_pc + PC_STEP;
        end
        boot = 1'b0;
    endtask

    task automatic fill_to(input int n);
        int k = 0;
        while (sb.size() < n && k < 30) begin
            cycle(1'b1, 1'b0, 1'b0, 32'd0);
            k++;
        end
        chk("fill_reached", 32'(sb.size()), 32'(n));
    endtask

    // Monitor: compares handshake outputs and pops the scoreboard on each accepted entry.
    initial begin
        forever begin
            @(chk_ev);
            #1;
            chk("i_req", 32'(i_req), 32'(exp_ireq));
            chk("dec_valid", 32'(dec_valid), 32'(exp_dvalid));
            chk("i_address", i_address, exp_addr);
            chk("count", 32'(count), 32'(exp_count));
            if (dec_valid && dec_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_nonempty", 32'd0, 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("dec_pc", dec_pc, mon_e.pc);
                    chk("dec_instr", dec_instr, mon_e.instr);
                end
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        reset_n        = 1'b0;
        i_data_valid   = 1'b0;
        i_data_read    = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        dec_ready      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        #1;
        reset_n = 1'b1;

        // Zero-wait ROM, decode always ready.
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Fill to FULL with decode stalled, then drain.
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // ROM wait states at address 8.
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'd0);

        // Redirect with a response in flight at count 3.
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        fill_to(3);
        cycle(1'b1, 1'b0, 1'b1, 32'h100);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Simultaneous push and pop at count 2 across pointer wrap.
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        fill_to(2);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Fetch PC wraps modulo 2^32.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Randomized traffic.
        repeat (400) begin
            cycle(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 65),
                  ($urandom_range(0, 99) < 4), $urandom);
        end

        // Asynchronous reset between edges at count 3.
        cycle(1'b0, 1'b0, 1'b1, 32'h40);
        fill_to(3);
        i_data_valid   = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dlx_fetch_queue.md
# dlx_fetch_queue

Parametrised instruction-fetch unit for the DLX pipeline: replaces the bare PC register feeding the instruction ROM with a fetch engine that honours `i_data_valid` wait states and buffers fetched instructions and their PCs in a DEPTH-entry queue ahead of decode. Decode consumes entries through a valid/ready handshake. A branch/jump redirect from ID or EX flushes the queue and restarts fetch at the new PC. The block sits between the instruction ROM port and the ID stage.

## Interface
Parameters:
- XLEN, 32, width of addresses and instructions
- DEPTH, 4, queue entries; power of two, ≥ 2
- PC_STEP, 4, PC increment per sequential fetch
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_address  out  XLEN  fetch address to the instruction ROM; equals fetch_pc
- i_req  out  1  fetch request
- i_data_valid  in  1  ROM response valid in the current cycle
- i_data_read  in  XLEN  instruction at i_address; sampled only when i_req && i_data_valid
- redirect_valid  in  1  flush the queue and restart fetch
- redirect_pc  in  XLEN  restart address; used as-is, no realignment
- dec_valid  out  1  head entry available to decode
- dec_ready  in  1  decode accepts the head entry
- dec_instr  out  XLEN  head-entry instruction
- dec_pc  out  XLEN  head-entry PC
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Reset values: fetch_pc = RESET_PC, count = 0, read and write pointers = 0, storage = 0, state = BOOT. Outputs: i_req = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0, i_address = RESET_PC.
- FSM states:
  - BOOT: entered on reset. i_req = 0. Moves unconditionally to RUN at the next edge.
  - RUN: i_req = !redirect_valid. Moves to FULL when count reaches DEPTH.
  - FULL: i_req = 0. Moves back to RUN when count < DEPTH.
- ROM protocol: one outstanding request. i_address is held stable while i_req = 1 and i_data_valid = 0. The ROM must tolerate i_req being withdrawn without a response.
- Push occurs on i_req && i_data_valid && !redirect_valid. It writes {fetch_pc, i_data_read} at the write pointer, then fetch_pc += PC_STEP (wrapping mod 2^XLEN).
- Pop: dec_valid = (count != 0) && !redirect_valid; pop occurs on dec_valid && dec_ready. dec_instr and dec_pc always show the head entry.
- Push and pop in the same cycle leave count unchanged and advance both pointers. Pointers wrap at DEPTH.
- Redirect (redirect_valid = 1 at an edge):
  - count := 0 and pointers := 0.
  - fetch_pc := redirect_pc.
  - No push or pop occurs in that cycle; a ROM response arriving in that cycle is discarded.
  - Next state is RUN, unless the state is BOOT, which still goes to RUN.
- Redirect has priority over every other event.
- count never exceeds DEPTH. The FULL state blocks pushes, so full with a simultaneous push cannot occur.

## Timing
- Fetch-to-decode latency: an instruction captured at edge N appears with dec_valid = 1 in cycle N+1.
- Throughput: 1 instruction/cycle with a zero-wait ROM and dec_ready held at 1.
- After reset release:
  - cycle 0: BOOT.
  - cycle 1: i_req = 1, i_address = RESET_PC.
  - cycle 2: first dec_valid, if the ROM responds in cycle 1.
- Redirect in cycle 0:
  - cycle 1: i_address = redirect_pc, i_req = 1, dec_valid = 0.
  - cycle 2: dec_pc = redirect_pc, with a zero-wait ROM.
- dec_valid and i_req depend combinationally on redirect_valid only. There is no combinational path from dec_ready to i_req.
- Asynchronous reset assertion forces all reset values immediately, mid-fetch or mid-handshake.

## Test plan
- Reset; zero-wait ROM returning address^32'hA5A50000; dec_ready = 1 → first dec_valid in cycle 2; dec_pc sequence 0, 4, 8, 12…; dec_instr matches the ROM pattern; count ≤ 1.
- dec_ready = 0 from reset → count reaches 4; state FULL; i_req = 0; i_address holds 16. Then dec_ready = 1 → pops 0, 4, 8, 12 on consecutive cycles; fetch resumes at 16; dec_pc = 16 follows 12 with no bubble beyond one cycle.
- i_data_valid low for 3 cycles while i_address = 8 → i_address stable at 8, no push, count unchanged. On the 4th cycle valid = 1 → entry {8, instr} pushed.
- count = 3, i_data_valid = 1 and redirect_valid = 1 with redirect_pc = 32'h100 → next cycle count = 0, dec_valid = 0, i_address = 32'h100. The in-flight response is discarded; the next dec_pc = 32'h100, then 32'h104.
- Simultaneous push and pop at count = 2 → count stays 2; order preserved across pointer wrap over 10 consecutive cycles.
- reset_n pulsed low asynchronously between edges at count = 3 → outputs take reset values before the next edge; after release the BOOT cycle occurs and fetch restarts at RESET_PC.
